// File: rtl/hex_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : hex_cmd_parser
//  Purpose  : Parses ASCII command lines "<dividend-hex>/<divisor-hex><CR>"
//             from the UART RX stream. Each valid line commits the 16-bit
//             dividend (D_end) and divisor (M) and raises a one-cycle
//             parser_done pulse. A malformed line raises a one-cycle err
//             pulse and is discarded.
//  Option   : `define DIV_ZERO_CHECK_EN to reject a zero divisor with err
//             instead of committing it.
//  Revision : 1.0  initial release
// ============================================================================
module hex_cmd_parser #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] D_end,
  output logic [15:0] M,
  output logic        parser_done,
  output logic        err,
  output logic        busy
);

  localparam int c_CW = $clog2(MAX_DIGITS + 1);
  localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX_DIGITS);

  localparam logic [7:0] c_SLASH = 8'h2F;
  localparam logic [7:0] c_CR    = 8'h0D;
  localparam logic [7:0] c_LF    = 8'h0A;
  localparam logic [7:0] c_SP    = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPA   = 2'd1,
    S_OPB   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t          r_state;
  logic [15:0]     r_acc_a;
  logic [15:0]     r_acc_b;
  logic [c_CW-1:0] r_cnt;
  logic [15:0]     r_d_end;
  logic [15:0]     r_m;
  logic            r_done;
  logic            r_err;

  logic            w_is_hex;
  logic [3:0]      w_nibble;
  logic            w_zero_div;

  // Classify the incoming byte and map hex characters to their nibble value.
  always_comb begin
    w_is_hex = 1'b0;
    w_nibble = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nibble = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      w_is_hex = 1'b1;
      w_nibble = rx_data[3:0] + 4'd9;
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  assign w_zero_div = (r_acc_b == 16'h0000);
`else
  assign w_zero_div = 1'b0;
`endif

  // Line-parsing FSM: accumulates operands, commits on CR, flags errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc_a <= 16'h0000;
      r_acc_b <= 16'h0000;
      r_cnt   <= '0;
      r_d_end <= 16'h0000;
      r_m     <= 16'h0000;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // LF is transparent in every state, so CR/LF line endings both work.
      if (rx_valid && rx_data != c_LF) begin
        case (r_state)
          S_IDLE: begin
            if (w_is_hex) begin
              r_acc_a <= {12'h000, w_nibble};
              r_acc_b <= 16'h0000;
              r_cnt   <= c_CW'(1);
              r_state <= S_OPA;
            end else if (rx_data == c_CR || rx_data == c_SP) begin
              r_state <= S_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_FLUSH;
            end
          end
          S_OPA: begin
            if (w_is_hex) begin
              if (r_cnt < c_MAX) begin
                r_acc_a <= {r_acc_a[11:0], w_nibble};
                r_cnt   <= r_cnt + c_CW'(1);
              end else begin
                r_err   <= 1'b1;
                r_state <= S_FLUSH;
              end
            end else if (rx_data == c_SLASH) begin
              r_cnt   <= '0;
              r_state <= S_OPB;
            end else if (rx_data == c_CR) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_FLUSH;
            end
          end
          S_OPB: begin
            if (w_is_hex) begin
              if (r_cnt < c_MAX) begin
                r_acc_b <= {r_acc_b[11:0], w_nibble};
                r_cnt   <= r_cnt + c_CW'(1);
              end else begin
                r_err   <= 1'b1;
                r_state <= S_FLUSH;
              end
            end else if (rx_data == c_CR) begin
              r_state <= S_IDLE;
              if (r_cnt == '0 || w_zero_div) begin
                r_err <= 1'b1;
              end else begin
                r_d_end <= r_acc_a;
                r_m     <= r_acc_b;
                r_done  <= 1'b1;
              end
            end else begin
              r_err   <= 1'b1;
              r_state <= S_FLUSH;
            end
          end
          S_FLUSH: begin
            // Only one err per line; everything up to CR is dropped silently.
            if (rx_data == c_CR) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign D_end       = r_d_end;
  assign M           = r_m;
  assign parser_done = r_done;
  assign err         = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hex_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_cmd_parser
//  Purpose  : Directed self-checking bench for hex_cmd_parser.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hex_cmd_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] D_end;
  logic [15:0] M;
  logic        parser_done;
  logic        err;
  logic        busy;

  int total;
  int bad;
  int dcnt;
  int ecnt;

  hex_cmd_parser #(.MAX_DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .D_end       (D_end),
    .M           (M),
    .parser_done (parser_done),
    .err         (err),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte strobe; outputs are sampled 1 ns after the edge that takes it.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (parser_done) dcnt++;
    if (err) ecnt++;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (parser_done) dcnt++;
      if (err) ecnt++;
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    dcnt     = 0;
    ecnt     = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dend", D_end, 16'h0000);
    chk("reset_m", M, 16'h0000);
    chk("reset_done", {15'd0, parser_done}, 16'd0);
    chk("reset_err", {15'd0, err}, 16'd0);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Basic line; pulse one cycle after CR strobe, drops next cycle.
    dcnt = 0; ecnt = 0;
    send_str("1234/0005");
    chk("l1_busy_mid", {15'd0, busy}, 16'd1);
    send(8'h0D);
    chk("l1_done", {15'd0, parser_done}, 16'd1);
    chk("l1_dend", D_end, 16'h1234);
    chk("l1_m", M, 16'h0005);
    idle(1);
    chk("l1_done_drop", {15'd0, parser_done}, 16'd0);
    chk("l1_ndone", dcnt[15:0], 16'd1);
    chk("l1_nerr", ecnt[15:0], 16'd0);

    // Mixed case, trailing LF, back-to-back strobes.
    dcnt = 0; ecnt = 0;
    send_str("ff/A\r\n");
    chk("l2_dend", D_end, 16'h00FF);
    chk("l2_m", M, 16'h000A);
    chk("l2_busy", {15'd0, busy}, 16'd0);
    chk("l2_ndone", dcnt[15:0], 16'd1);
    chk("l2_nerr", ecnt[15:0], 16'd0);

    // Blank line and leading spaces in IDLE are harmless.
    dcnt = 0; ecnt = 0;
    send_str("\r  5/5\r");
    chk("l3_dend", D_end, 16'h0005);
    chk("l3_m", M, 16'h0005);
    chk("l3_ndone", dcnt[15:0], 16'd1);
    chk("l3_nerr", ecnt[15:0], 16'd0);

    // Dividend overflow: err on the fifth digit, rest of line flushed.
    dcnt = 0; ecnt = 0;
    send_str("1234");
    send("5");
    chk("ovf_err_on5", {15'd0, err}, 16'd1);
    chk("ovf_busy", {15'd0, busy}, 16'd1);
    send_str("/1\r");
    chk("ovf_busy_after", {15'd0, busy}, 16'd0);
    chk("ovf_ndone", dcnt[15:0], 16'd0);
    chk("ovf_nerr", ecnt[15:0], 16'd1);
    chk("ovf_dend_hold", D_end, 16'h0005);
    dcnt = 0; ecnt = 0;
    send_str("8/2\r");
    chk("l4_done", {15'd0, parser_done}, 16'd1);
    chk("l4_dend", D_end, 16'h0008);
    chk("l4_m", M, 16'h0002);

    // Divisor overflow.
    dcnt = 0; ecnt = 0;
    send_str("1/FFFF");
    send("F");
    chk("ovfb_err", {15'd0, err}, 16'd1);
    send(8'h0D);
    chk("ovfb_ndone", dcnt[15:0], 16'd0);
    chk("ovfb_m_hold", M, 16'h0002);

    // Empty divisor: err on the CR itself, back to IDLE.
    dcnt = 0; ecnt = 0;
    send_str("12/");
    send(8'h0D);
    chk("empty_err_cr", {15'd0, err}, 16'd1);
    chk("empty_busy", {15'd0, busy}, 16'd0);
    // CR with no slash is also an error.
    send_str("12");
    send(8'h0D);
    chk("noslash_err_cr", {15'd0, err}, 16'd1);
    chk("noslash_busy", {15'd0, busy}, 16'd0);

    // Bad character: single err on 'x', flushed until CR.
    send("1");
    send("x");
    chk("badch_err", {15'd0, err}, 16'd1);
    send_str("/2\r");
    chk("badch_nerr", ecnt[15:0], 16'd3);
    chk("badch_ndone", dcnt[15:0], 16'd0);
    chk("badch_dend_hold", D_end, 16'h0008);
    chk("badch_m_hold", M, 16'h0002);

    // Zero divisor.
    dcnt = 0; ecnt = 0;
    send_str("10/0\r");
`ifdef DIV_ZERO_CHECK_EN
    chk("dz_err", {15'd0, err}, 16'd1);
    chk("dz_done", {15'd0, parser_done}, 16'd0);
    chk("dz_dend", D_end, 16'h0008);
    chk("dz_m", M, 16'h0002);
`else
    chk("dz_done", {15'd0, parser_done}, 16'd1);
    chk("dz_err", {15'd0, err}, 16'd0);
    chk("dz_dend", D_end, 16'h0010);
    chk("dz_m", M, 16'h0000);
`endif
    chk("dz_busy", {15'd0, busy}, 16'd0);

    // Asynchronous reset mid-line discards the partial line.
    send_str("AB/");
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_dend", D_end, 16'h0000);
    chk("arst_m", M, 16'h0000);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_done", {15'd0, parser_done}, 16'd0);
    chk("arst_err", {15'd0, err}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0; ecnt = 0;
    send_str("7/3\r");
    chk("post_rst_done", {15'd0, parser_done}, 16'd1);
    chk("post_rst_dend", D_end, 16'h0007);
    chk("post_rst_m", M, 16'h0003);
    chk("post_rst_nerr", ecnt[15:0], 16'd0);
    idle(2);
    chk("post_rst_ndone", dcnt[15:0], 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_cmd_parser.md
Name: hex_cmd_parser

Overview:
- Upstream stage of the UART hex calculator divider.
- Consumes received ASCII bytes from the UART RX block and parses a command line of the form "<dividend-hex>/<divisor-hex><CR>".
- On a valid line, commits the 16-bit dividend (D_end) and divisor (M) and issues a one-cycle parser_done pulse that starts the divider.
- Malformed lines produce an err pulse and are discarded.

Parameters:
- MAX_DIGITS, 4, maximum hex digits accepted per operand (legal range 1..4); operand width is fixed at 16 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received ASCII byte; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte; back-to-back strobes are legal.
- D_end  output  16  committed dividend; held until the next commit.
- M  output  16  committed divisor; held until the next commit.
- parser_done  output  1  one-cycle pulse; the operands are valid in the same cycle.
- err  output  1  one-cycle pulse on a syntax or overflow error.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-high on rst. On rst=1 the block immediately forces the following, regardless of clk:
  - state=IDLE; acc_a, acc_b, digit count, D_end and M = 0.
  - parser_done, err and busy = 0.
  - Reset mid-line discards the partial line.
- Bytes are processed only in cycles with rx_valid=1; in all other cycles state and accumulators hold.
- Character classes:
  - HEX = '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66), mapped to nibbles 0-15.
  - SLASH = 0x2F.
  - CR = 0x0D.
  - LF = 0x0A; ignored in every state with no state change.
  - SP = 0x20; ignored in IDLE only.
- Accumulate rule: acc <= {acc[11:0], nibble}; the digit count increments by 1.
- FSM states: IDLE, OPA, OPB, FLUSH.
- IDLE:
  - HEX: acc_a <= nibble, acc_b <= 0, cnt=1, go to OPA.
  - CR: stay in IDLE, no pulse (blank line).
  - Any other byte: err pulse, go to FLUSH.
- OPA:
  - HEX with cnt<MAX_DIGITS: accumulate into acc_a.
  - HEX with cnt==MAX_DIGITS: err pulse, go to FLUSH (overflow).
  - SLASH: cnt <= 0, go to OPB.
  - CR: err pulse, go to IDLE.
  - Any other byte: err pulse, go to FLUSH.
- OPB:
  - HEX: same digit and overflow rules as OPA, applied to acc_b.
  - CR with cnt>=1: commit, go to IDLE.
  - CR with cnt==0: err pulse, go to IDLE.
  - Any other byte: err pulse, go to FLUSH.
- FLUSH:
  - Discard all bytes until CR, then go to IDLE.
  - No further err pulses for the same line.
- Commit:
  - On the clock edge that samples the terminating CR, D_end<=acc_a, M<=acc_b and parser_done<=1.
  - parser_done drops the next cycle.
  - Latency: one cycle from the CR strobe to the pulse.
- err is asserted on the edge that samples the offending byte and lasts one cycle.
- parser_done and err are never asserted in the same cycle.
- D_end and M change only on commit. They stay stable between commits, so the divider may read them for its whole run.
- At most one parser_done per line. A new line may start on the cycle immediately after CR.

Optional Feature:
- Macro: DIV_ZERO_CHECK_EN.
- Defined: a CR in OPB with cnt>=1 and acc_b==0 produces an err pulse instead of a commit. D_end, M and parser_done are unchanged, and the FSM returns to IDLE.
- Undefined: a zero divisor commits normally, M=0 is output and parser_done pulses.

Test Plan:
- Bytes "1234/0005\r" -> one parser_done pulse one cycle after the CR strobe; D_end=0x1234, M=0x0005; err never asserted.
- Bytes "ff/A\r\n" back-to-back strobes -> D_end=0x00FF, M=0x000A; mixed case accepted; LF ignored; busy returns to 0 after CR.
- Bytes "12345/1\r" with MAX_DIGITS=4 -> err pulse on the '5' strobe; no parser_done; the next line "8/2\r" gives D_end=0x0008, M=0x0002.
- Bytes "12/\r" -> err pulse on the CR and state returns to IDLE; bytes "1x/2\r" -> a single err pulse on 'x', FLUSH until CR; D_end and M keep their prior values in both cases.
- Bytes "10/0\r" -> with DIV_ZERO_CHECK_EN: err pulse, no parser_done; without it: parser_done with D_end=0x0010, M=0x0000.
- Assert rst for one cycle after receiving "AB/" -> all outputs read 0; the following "7/3\r" commits D_end=0x0007, M=0x0003.
